// File: rtl/cache_line_fill.sv
// cache_line_fill
//   Miss-handling stage between a direct-mapped 4-column data cache and
//   external RAM. On an accepted miss it reads the 4 words of the addressed
//   line, one memory handshake per word. Each returned word is presented to
//   the cache write port for exactly one cycle. Completion, or a timeout
//   error, is reported to the requester.
//
//   Optional feature: define CACHE_LINE_FILL_CRITICAL_WORD_FIRST_EN to start
//   the fill at column miss_address[3:2], wrapping modulo 4. Without it the
//   fill always runs columns 0,1,2,3.
//
// Handshake: mem_req rises with a valid mem_address and both hold steady
//   until a one-cycle mem_ready strobe. mem_data is captured in that same
//   cycle. mem_ready while mem_req is low is ignored.
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   miss_req           start a fill (sampled only when idle)
//   miss_address       missing address; bits [3:0] select column/byte
//   busy               high from the cycle after acceptance until back in idle
//   done               one-cycle end-of-fill pulse (success or error)
//   error              set with done on timeout; cleared on the next acceptance
//   mem_req            word read request, held until mem_ready
//   mem_address        word address of the current request
//   mem_ready          one-cycle strobe qualifying mem_data
//   mem_data           read data
//   fill_address       word address presented to the cache
//   fill_data          word presented to the cache
//   fill_write_enable  4'b1111 during the single write cycle of a word, else 0
//   dbg_state          current FSM state (0 idle, 1 fetch, 2 write, 3 done)

module cache_line_fill #(
    parameter int LINE_IX_BITWIDTH = 8,
    parameter int TIMEOUT_CYCLES   = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        miss_req,
    input  logic [31:0] miss_address,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        mem_req,
    output logic [31:0] mem_address,
    input  logic        mem_ready,
    input  logic [31:0] mem_data,
    output logic [31:0] fill_address,
    output logic [31:0] fill_data,
    output logic [3:0]  fill_write_enable,
    output logic [1:0]  dbg_state
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    // The line index plus the 4-bit column/byte offset must fit the address.
    if (TIMEOUT_CYCLES < 2 || LINE_IX_BITWIDTH < 1 || LINE_IX_BITWIDTH > 28) begin : g_param_check
        $error("cache_line_fill: illegal LINE_IX_BITWIDTH or TIMEOUT_CYCLES");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state_q;
    logic [27:0]     base_q;   // line base address bits [31:4]
    logic [1:0]      col_q;    // column currently being fetched
    logic [1:0]      words_q;  // words already written in this fill
    logic [TW-1:0]   tmo_q;    // cycles spent waiting for mem_ready
    logic [1:0]      col_d;
    logic [1:0]      start_col;
    logic            unused_addr_bits;

`ifdef CACHE_LINE_FILL_CRITICAL_WORD_FIRST_EN
    assign start_col        = miss_address[3:2];
    assign unused_addr_bits = ^miss_address[1:0];
`else
    assign start_col        = 2'd0;
    assign unused_addr_bits = ^miss_address[3:0];
`endif

    // Column order wraps 3 -> 0 through the natural 2-bit overflow.
    assign col_d     = col_q + 2'd1;
    assign dbg_state = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= S_IDLE;
            base_q            <= '0;
            col_q             <= '0;
            words_q           <= '0;
            tmo_q             <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
            error             <= 1'b0;
            mem_req           <= 1'b0;
            mem_address       <= '0;
            fill_address      <= '0;
            fill_data         <= '0;
            fill_write_enable <= '0;
        end else begin
            // Pulsed outputs default low; the tag is only written in S_WRITE.
            done              <= 1'b0;
            fill_write_enable <= '0;
            case (state_q)
                S_IDLE: begin
                    if (miss_req) begin
                        base_q      <= miss_address[31:4];
                        col_q       <= start_col;
                        words_q     <= '0;
                        tmo_q       <= '0;
                        error       <= 1'b0;
                        busy        <= 1'b1;
                        mem_req     <= 1'b1;
                        mem_address <= {miss_address[31:4], start_col, 2'b00};
                        state_q     <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (mem_ready) begin
                        fill_data         <= mem_data;
                        fill_address      <= mem_address;
                        fill_write_enable <= 4'b1111;
                        mem_req           <= 1'b0;
                        tmo_q             <= '0;
                        state_q           <= S_WRITE;
                    end else if (tmo_q == TMO_LAST) begin
                        // Give up on this line; already-written words stay valid
                        // in the cache, so the requester must re-request.
                        mem_req <= 1'b0;
                        error   <= 1'b1;
                        done    <= 1'b1;
                        tmo_q   <= '0;
                        state_q <= S_DONE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                S_WRITE: begin
                    if (words_q == 2'd3) begin
                        done    <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        col_q       <= col_d;
                        words_q     <= words_q + 2'd1;
                        mem_req     <= 1'b1;
                        mem_address <= {base_q, col_d, 2'b00};
                        state_q     <= S_FETCH;
                    end
                end
                S_DONE: begin
                    busy    <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_line_fill.sv
// Directed bench for cache_line_fill (TIMEOUT_CYCLES = 8).
// Memory model answers each word with 32'hA0 + column after a programmable
// number of wait cycles. Fill writes are captured by a monitor and compared
// against an expected queue built from hand-derived addresses and cycles.

module tb_cache_line_fill;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        miss_req = 1'b0;
    logic [31:0] miss_address = '0;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_data = '0;
    logic        busy, done, error, mem_req;
    logic [31:0] mem_address, fill_address, fill_data;
    logic [3:0]  fill_write_enable;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // memory model controls (written only by the main process)
    int wait_cycles = 0;
    int mute_idx    = -1;
    logic stray_en  = 1'b0;

    // scoreboard
    logic [31:0] exp_q[$];
    logic [31:0] exp_d_q[$];
    logic [31:0] exp_c_q[$];
    logic [31:0] wr_a_q[$];
    logic [31:0] wr_d_q[$];
    logic [31:0] wr_c_q[$];

    cache_line_fill #(
        .LINE_IX_BITWIDTH(8),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .miss_req(miss_req),
        .miss_address(miss_address),
        .busy(busy),
        .done(done),
        .error(error),
        .mem_req(mem_req),
        .mem_address(mem_address),
        .mem_ready(mem_ready),
        .mem_data(mem_data),
        .fill_address(fill_address),
        .fill_data(fill_data),
        .fill_write_enable(fill_write_enable),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [1:0] start_col(input logic [31:0] a);
`ifdef CACHE_LINE_FILL_CRITICAL_WORD_FIRST_EN
        return a[3:2];
`else
        return 2'd0;
`endif
    endfunction

    // ---------------- memory model ----------------
    int          wait_cnt = 0;
    int          req_idx  = 0;
    logic [31:0] req_addr = '0;

    always @(negedge clk) begin
        mem_ready = 1'b0;
        if (!busy) req_idx = 0;
        if (mem_req) begin
            if (wait_cnt == 0) req_addr = mem_address;
            else check("mem_addr_stable", mem_address, req_addr);
            if (req_idx != mute_idx && wait_cnt >= wait_cycles) begin
                mem_ready = 1'b1;
                mem_data  = 32'hA0 + {30'b0, mem_address[3:2]};
                req_idx++;
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            // a request dropped before its answer is only legal at timeout
            if (wait_cnt != 0 && !done) check("mem_req_held", {31'b0, mem_req}, 32'd1);
            wait_cnt = 0;
            if (stray_en && fill_write_enable != 4'b0000) mem_ready = 1'b1;
        end
    end

    // ---------------- write monitor ----------------
    logic [3:0] prev_fwe = '0;
    always @(negedge clk) begin
        if (fill_write_enable != 4'b0000) begin
            check("fwe_value", {28'b0, fill_write_enable}, 32'hF);
            check("fwe_one_cycle", {28'b0, prev_fwe}, 32'h0);
            wr_a_q.push_back(fill_address);
            wr_d_q.push_back(fill_data);
            wr_c_q.push_back(cyc);
        end
        prev_fwe = fill_write_enable;
    end

    // ---------------- driver tasks ----------------
    task automatic issue_miss(input logic [31:0] addr, output int acc);
        miss_address = addr;
        miss_req     = 1'b1;
        acc          = cyc;
        @(negedge clk);
        miss_req     = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wait_done(input int bound, output int done_at, output logic err);
        done_at = -1;
        err     = 1'b0;
        for (int k = 0; k < bound; k++) begin
            if (done) begin
                done_at = cyc;
                err     = error;
                break;
            end
            @(negedge clk);
        end
        if (done_at < 0) check("done_seen", 32'd0, 32'd1);
    endtask

    task automatic expect_writes(input logic [31:0] base, input logic [1:0] first,
                                 input int n, input int acc, input int per_word);
        for (int i = 0; i < n; i++) begin
            logic [1:0] c;
            c = first + 2'(i);
            exp_q.push_back(base | {28'b0, c, 2'b00});
            exp_d_q.push_back(32'hA0 + {30'b0, c});
            exp_c_q.push_back(32'(acc + per_word * (i + 1)));
        end
    endtask

    task automatic score(input string tag);
        check({tag, "_count"}, wr_a_q.size(), exp_q.size());
        while (exp_q.size() > 0 && wr_a_q.size() > 0) begin
            check({tag, "_addr"}, wr_a_q.pop_front(), exp_q.pop_front());
            check({tag, "_data"}, wr_d_q.pop_front(), exp_d_q.pop_front());
            check({tag, "_cycle"}, wr_c_q.pop_front(), exp_c_q.pop_front());
        end
        exp_q.delete(); exp_d_q.delete(); exp_c_q.delete();
        wr_a_q.delete(); wr_d_q.delete(); wr_c_q.delete();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, {31'b0, busy}, 32'd0);
        check({tag, "_done"}, {31'b0, done}, 32'd0);
        check({tag, "_error"}, {31'b0, error}, 32'd0);
        check({tag, "_mem_req"}, {31'b0, mem_req}, 32'd0);
        check({tag, "_mem_address"}, mem_address, 32'd0);
        check({tag, "_fill_address"}, fill_address, 32'd0);
        check({tag, "_fill_data"}, fill_data, 32'd0);
        check({tag, "_fwe"}, {28'b0, fill_write_enable}, 32'd0);
        check({tag, "_state"}, {30'b0, dbg_state}, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int          acc;
        int          done_at;
        logic        err;
        logic [31:0] a;

        // reset, then idle
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_idle_outputs("reset_idle");
        end

        // zero-wait fill: writes at acc+2,4,6,8, done at acc+9
        a = 32'h0000_1238;
        issue_miss(a, acc);
        check("zw_busy_next", {31'b0, busy}, 32'd1);
        check("zw_mem_req_next", {31'b0, mem_req}, 32'd1);
        check("zw_first_addr", mem_address, 32'h1230 | {28'b0, start_col(a), 2'b00});
        wait_done(40, done_at, err);
        check("zw_done_cycle", done_at, acc + 9);
        check("zw_error", {31'b0, err}, 32'd0);
        @(negedge clk);
        check("zw_done_pulse", {31'b0, done}, 32'd0);
        check("zw_busy_after", {31'b0, busy}, 32'd0);
        check("zw_state_after", {30'b0, dbg_state}, 32'd0);
        expect_writes(32'h1230, start_col(a), 4, acc, 2);
        score("zw");

        // 3 wait cycles per word: FETCH lasts 4 cycles, 5 cycles per word
        wait_cycles = 3;
        a = 32'h0000_ABC4;
        issue_miss(a, acc);
        wait_done(60, done_at, err);
        check("ws_done_cycle", done_at, acc + 21);
        check("ws_error", {31'b0, err}, 32'd0);
        @(negedge clk);
        expect_writes(32'hABC0, start_col(a), 4, acc, 5);
        score("ws");
        wait_cycles = 0;

        // timeout on word 1: word 0 written, 8 unanswered FETCH cycles
        mute_idx = 1;
        a = 32'h0000_200C;
        issue_miss(a, acc);
        wait_done(40, done_at, err);
        check("to_done_cycle", done_at, acc + 11);
        check("to_error_with_done", {31'b0, err}, 32'd1);
        @(negedge clk);
        check("to_error_held", {31'b0, error}, 32'd1);
        check("to_busy_after", {31'b0, busy}, 32'd0);
        check("to_state_after", {30'b0, dbg_state}, 32'd0);
        check("to_mem_req_after", {31'b0, mem_req}, 32'd0);
        expect_writes(32'h2000, start_col(a), 1, acc, 2);
        score("to");
        mute_idx = -1;
        a = 32'h0000_3004;
        issue_miss(a, acc);
        check("to_error_cleared", {31'b0, error}, 32'd0);
        wait_done(40, done_at, err);
        check("to_retry_done_cycle", done_at, acc + 9);
        check("to_retry_error", {31'b0, err}, 32'd0);
        @(negedge clk);
        expect_writes(32'h3000, start_col(a), 4, acc, 2);
        score("to_retry");

        // miss_req during FETCH of word 2 and stray mem_ready during WRITE
        stray_en = 1'b1;
        a = 32'h0000_5678;
        issue_miss(a, acc);
        wait_until(acc + 5);
        miss_address = 32'hDEAD_0000;
        miss_req = 1'b1;
        @(negedge clk);
        miss_req = 1'b0;
        wait_done(40, done_at, err);
        check("ig_done_cycle", done_at, acc + 9);
        check("ig_error", {31'b0, err}, 32'd0);
        @(negedge clk);
        stray_en = 1'b0;
        repeat (4) @(negedge clk);
        check("ig_still_idle", {30'b0, dbg_state}, 32'd0);
        expect_writes(32'h5670, start_col(a), 4, acc, 2);
        score("ig");

        // reset in the cycle after the second WRITE
        a = 32'h0000_9AB0;
        issue_miss(a, acc);
        wait_until(acc + 5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle_outputs("rst_mid");
        repeat (12) @(negedge clk);
        check("rst_no_mem_req", {31'b0, mem_req}, 32'd0);
        check("rst_state_idle", {30'b0, dbg_state}, 32'd0);
        expect_writes(32'h9AB0, start_col(a), 2, acc, 2);
        score("rst_partial");
        a = 32'h0000_CDE4;
        issue_miss(a, acc);
        wait_done(40, done_at, err);
        check("rst_refill_done_cycle", done_at, acc + 9);
        check("rst_refill_error", {31'b0, err}, 32'd0);
        @(negedge clk);
        expect_writes(32'hCDE0, start_col(a), 4, acc, 2);
        score("rst_refill");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_line_fill.md
Name: cache_line_fill

Overview:
- Miss-handling stage between the direct-mapped 4-column data cache and external RAM.
- On a miss request it fetches the 4 words of the addressed line, one per memory handshake.
- It drives each word into the cache's write port, which also writes the tag and sets the valid bit.
- It signals completion, or a timeout error, to the requester.

Parameters:
- LINE_IX_BITWIDTH, 8, line index width; must match the cache instance.
- TIMEOUT_CYCLES, 1024, maximum cycles to wait for mem_ready per word (>=2).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- miss_req  in  1  start a fill; sampled only in IDLE
- miss_address  in  32  address that missed; bits [3:0] select column/byte
- busy  out  1  high from the cycle after acceptance until return to IDLE
- done  out  1  one-cycle pulse at end of fill (success or error)
- error  out  1  set with done on timeout; cleared when the next miss_req is accepted
- mem_req  out  1  word read request, held until mem_ready
- mem_address  out  32  word address of current request, bits [1:0]=0
- mem_ready  in  1  one-cycle strobe: mem_data valid for current request
- mem_data  in  32  read data
- fill_address  out  32  address presented to cache during write
- fill_data  out  32  word presented to cache
- fill_write_enable  out  4  byte enables to cache; 4'b1111 during a fill write, else 0

Behaviour:
- All outputs are registered. Reset values: busy=0, done=0, error=0, mem_req=0, mem_address=0, fill_address=0, fill_data=0, fill_write_enable=0. State=IDLE, counters=0.
- Line base = {miss_address[31:4], 4'b0}, latched on acceptance. Word address = base | (col<<2). col is a 2-bit counter that wraps 3->0 modulo 4.
- States:
  - IDLE: if miss_req, latch base and start column, clear error, and go to FETCH. mem_req=1 and busy=1 from the next cycle.
  - FETCH: mem_req=1, mem_address=current word. A timeout counter increments each cycle mem_ready=0.
    - On mem_ready: latch mem_data and the word address, set mem_req=0, go to WRITE, reset the timeout counter.
    - If the counter reaches TIMEOUT_CYCLES-1 with no mem_ready: go to DONE with error=1.
  - WRITE: exactly one cycle with fill_write_enable=4'b1111, fill_address and fill_data valid.
    - If this was the 4th word, go to DONE.
    - Otherwise advance col and go to FETCH; mem_req rises the following cycle.
  - DONE: done=1 for one cycle, busy drops, then IDLE.
- Latency with zero-wait memory (mem_ready in the first FETCH cycle):
  - acceptance to first write: 2 cycles
  - per word: 2 cycles
  - acceptance to done: 9 cycles
- mem_ready while mem_req=0 is ignored. miss_req while busy is ignored and not queued.
- fill_write_enable is never nonzero outside WRITE. Other cycles drive 0 so the cache's tag is not written.
- Timeout mid-line: words already written stay in the cache with the valid bit set. The requester must treat error as "line content undefined" and re-request.
- rst asserted mid-fill: next cycle IDLE, all outputs at reset values, no further writes or mem_req. The partially filled line has the same caveat as a timeout.
- miss_req and rst high in the same cycle: reset wins.

Optional Feature:
- Macro: CACHE_LINE_FILL_CRITICAL_WORD_FIRST_EN
- Defined: start column = miss_address[3:2]. Order wraps, e.g. start 2 gives 2,3,0,1.
- Undefined: start column always 0, giving order 0,1,2,3 regardless of miss_address[3:2].
- All other timing is identical in both builds.

Test Plan:
- Reset, then idle 5 cycles -> all outputs 0, no mem_req.
- miss_address=0x0000_1238, mem_ready in the first FETCH cycle, data 0xA0..0xA3 -> fill writes to 0x1230/4/8/C in order 0,1,2,3 (macro off) or 2,3,0,1 (macro on). done pulses 9 cycles after acceptance, error=0.
- Memory with 3 wait cycles per word -> mem_req held steady with a stable mem_address until mem_ready. Each fill_write_enable=4'b1111 lasts exactly 1 cycle.
- TIMEOUT_CYCLES=8, memory never answers word 1 -> word 0 written, done=1 and error=1 together, then IDLE. The next miss_req clears error.
- miss_req pulsed during the FETCH of word 2, plus a stray mem_ready during WRITE -> both ignored, word sequence unchanged, exactly 4 writes.
- rst asserted in the cycle after the second WRITE -> next cycle all outputs 0 and state IDLE. No third write ever occurs, and a new miss_req is then accepted normally.
